// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_stage_lsu_pkg;

  typedef logic [63:0] dw_t;
  typedef logic [7:0]  strb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Offset bits that must be zero for a naturally aligned access of size 2**sz bytes.
  function automatic logic [2:0] off_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_mem_align.sv
// Combinational lane steering: store replication/shift and strobes, load extract/extend,
// and natural-alignment check.
module mem_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] off,
  input  dw_t        st_data,
  input  dw_t        rd_data,
  output dw_t        wdata,
  output strb_t      strb,
  output dw_t        ld_data,
  output logic       misaligned
);

  logic [1:0] sz;
  logic [5:0] sh;
  dw_t        st_repl;
  dw_t        rd_lane;

  assign sz = funct3[1:0];
  assign sh = {off, 3'b000};

  // Replicate the low 'size' bytes of the store data across the doubleword.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_repl
      assign st_repl[gi*8 +: 8] = (sz == 2'b00) ? st_data[7:0] :
                                  (sz == 2'b01) ? st_data[(gi%2)*8 +: 8] :
                                  (sz == 2'b10) ? st_data[(gi%4)*8 +: 8] :
                                                  st_data[gi*8 +: 8];
    end
  endgenerate

  assign wdata = st_repl << sh;

  always_comb begin
    strb = '0;
    case (sz)
      2'b00:   strb = strb_t'(8'h01 << off);
      2'b01:   strb = strb_t'(8'h03 << off);
      2'b10:   strb = strb_t'(8'h0F << off);
      default: strb = 8'hFF;
    endcase
  end

  assign rd_lane = rd_data >> sh;

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{56{rd_lane[7]}},  rd_lane[7:0]};
      F3_H:    ld_data = {{48{rd_lane[15]}}, rd_lane[15:0]};
      F3_W:    ld_data = {{32{rd_lane[31]}}, rd_lane[31:0]};
      F3_D:    ld_data = rd_lane;
      F3_BU:   ld_data = {56'd0, rd_lane[7:0]};
      F3_HU:   ld_data = {48'd0, rd_lane[15:0]};
      F3_WU:   ld_data = {32'd0, rd_lane[31:0]};
      default: ld_data = '0;
    endcase
  end

  assign misaligned = |(off & off_mask(sz));

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one load/store per instruction over a req/ack data-memory port,
// stalling upstream stages until the access completes.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int DM_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_M,
  input  logic                 mem_read_M,
  input  logic                 mem_write_M,
  input  logic [2:0]           funct3_M,
  input  logic [XLEN-1:0]      alu_out_M,
  input  logic [XLEN-1:0]      rs2_data_M,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [63:0]          dm_wdata,
  output logic [7:0]           dm_strb,
  input  logic                 dm_ack,
  input  logic [63:0]          dm_rdata,
  output logic                 stall_M,
  output logic [XLEN-1:0]      load_data_M,
  output logic                 exc_M
);

  lsu_state_t           state_reg, state_next;
  logic                 req_reg;
  logic                 we_reg;
  logic [DM_ADDR_W-1:0] addr_reg;
  dw_t                  wdata_reg;
  strb_t                strb_reg;
  dw_t                  load_reg;
  logic [2:0]           f3_reg;
  logic [2:0]           off_reg;

  logic                 acc;
  logic                 illegal;
  logic                 misaligned;
  logic                 exc_raw;
  logic                 accept;
  logic                 stall_raw;
  logic                 capture;
  logic [2:0]           align_f3;
  logic [2:0]           align_off;
  dw_t                  align_wdata;
  dw_t                  align_ld;
  strb_t                align_strb;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^alu_out_M[XLEN-1:DM_ADDR_W];

  assign acc     = valid_M & (mem_read_M | mem_write_M);
  // A set read bit wins, so the access is a load whenever mem_read_M is high.
  assign illegal = mem_read_M ? (funct3_M == 3'b111) : funct3_M[2];
  assign exc_raw = (state_reg == IDLE) & acc & (misaligned | illegal);
  assign accept  = (state_reg == IDLE) & acc & ~(misaligned | illegal);
  assign capture = (state_reg == REQ) & dm_ack & ~we_reg;

  // Outside IDLE the E->M inputs are frozen, but the registered copies make the
  // load extract independent of that.
  assign align_f3  = (state_reg == IDLE) ? funct3_M       : f3_reg;
  assign align_off = (state_reg == IDLE) ? alu_out_M[2:0] : off_reg;

  mem_align u_align (
    .funct3     (align_f3),
    .off        (align_off),
    .st_data    (rs2_data_M),
    .rd_data    (dm_rdata),
    .wdata      (align_wdata),
    .strb       (align_strb),
    .ld_data    (align_ld),
    .misaligned (misaligned)
  );

  always_comb begin
    state_next = state_reg;
    stall_raw  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = REQ;
          stall_raw  = 1'b1;
        end
      end
      REQ: begin
        stall_raw = 1'b1;
        if (dm_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      load_reg  <= '0;
      f3_reg    <= '0;
      off_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_reg   <= 1'b1;
        we_reg    <= ~mem_read_M;
        addr_reg  <= {alu_out_M[DM_ADDR_W-1:3], 3'b000};
        wdata_reg <= mem_read_M ? '0 : align_wdata;
        strb_reg  <= mem_read_M ? '0 : align_strb;
        f3_reg    <= funct3_M;
        off_reg   <= alu_out_M[2:0];
      end else if ((state_reg == REQ) && dm_ack) begin
        req_reg <= 1'b0;
      end
      if (capture) begin
        load_reg <= align_ld;
      end
    end
  end

  assign dm_req      = req_reg;
  assign dm_we       = we_reg;
  assign dm_addr     = addr_reg;
  assign dm_wdata    = wdata_reg;
  assign dm_strb     = strb_reg;
  assign load_data_M = load_reg;
  assign stall_M     = rst & stall_raw;
  assign exc_M       = rst & exc_raw;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised scoreboard bench for mem_stage_lsu with a byte-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_M = 1'b0;
  logic        mem_read_M = 1'b0;
  logic        mem_write_M = 1'b0;
  logic [2:0]  funct3_M = '0;
  logic [63:0] alu_out_M = '0;
  logic [63:0] rs2_data_M = '0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_strb;
  logic        dm_ack = 1'b0;
  logic [63:0] dm_rdata = '0;
  logic        stall_M;
  logic [63:0] load_data_M;
  logic        exc_M;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(64), .DM_ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_M     (valid_M),
    .mem_read_M  (mem_read_M),
    .mem_write_M (mem_write_M),
    .funct3_M    (funct3_M),
    .alu_out_M   (alu_out_M),
    .rs2_data_M  (rs2_data_M),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_strb     (dm_strb),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .stall_M     (stall_M),
    .load_data_M (load_data_M),
    .exc_M       (exc_M)
  );

  typedef struct {
    logic        exc;
    logic        ld;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] ldval;
    int          lat;
  } exp_t;

  typedef struct {
    int          lat;
    logic [63:0] rdata;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   stray_all = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, want);
  endtask

  task automatic fail(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference: byte lanes of the doubleword, natural alignment, read bit wins.
  function automatic exp_t model(input logic rd, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] st, input logic [63:0] rdata, input int lat);
    exp_t        e;
    int          size;
    int          off;
    logic [63:0] v;
    size    = 1 << f3[1:0];
    off     = int'(addr[2:0]);
    e.ld    = rd;
    e.lat   = lat;
    e.exc   = (rd ? (f3 == 3'b111) : f3[2]) || ((off % size) != 0);
    e.addr  = addr[31:0] & ~32'h7;
    e.wdata = '0;
    e.strb  = '0;
    for (int j = 0; j < 8; j++) begin
      if (j >= off) begin
        e.wdata[j*8 +: 8] = st[((j - off) % size)*8 +: 8];
        if (j < off + size) e.strb[j] = 1'b1;
      end
    end
    v = '0;
    for (int i = 0; i < size && off + i < 8; i++) v[i*8 +: 8] = rdata[(off + i)*8 +: 8];
    if (!f3[2] && size < 8 && v[size*8-1]) v = v | (~64'd0 << (size*8));
    e.ldval = v;
    return e;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] st, input logic [63:0] rdata, input int lat);
    exp_t e;
    rsp_t r;
    logic s;
    int   cyc;
    e = model(rd, f3, addr, st, rdata, lat);
    valid_M = 1'b1; mem_read_M = rd; mem_write_M = wr;
    funct3_M = f3; alu_out_M = addr; rs2_data_M = st;
    exp_q.push_back(e);
    if (!e.exc) begin
      r.lat = lat; r.rdata = rdata;
      rsp_q.push_back(r);
    end
    $display("txn rd=%0b wr=%0b f3=%0d addr=0x%h st=0x%h rdata=0x%h lat=%0d exc=%0b",
             rd, wr, f3, addr, st, rdata, lat, e.exc);
    cyc = 0;
    do begin
      @(negedge clk); s = stall_M;
      @(posedge clk); #1; cyc++;
    end while (s && cyc < 100);
    if (s) fail("issue_timeout", "stall_M still high after 100 cycles, required release");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      valid_M = 1'($urandom);
      if (valid_M) begin
        mem_read_M = 1'b0; mem_write_M = 1'b0;
      end else begin
        mem_read_M = 1'($urandom); mem_write_M = 1'($urandom);
      end
      funct3_M = 3'($urandom); alu_out_M = {$urandom, $urandom}; rs2_data_M = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  // Memory responder: acks the Nth REQ cycle; random stray acks whenever no request is open.
  initial begin : responder
    rsp_t cur;
    int   cnt;
    bit   active;
    active = 1'b0; cnt = 0; cur.lat = 1; cur.rdata = '0;
    forever begin
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = {$urandom, $urandom};
      if (!rst) begin
        active = 1'b0;
        rsp_q.delete();
      end else if (dm_req) begin
        if (!active) begin
          if (rsp_q.size() == 0) begin
            fail("rsp_underflow", "dm_req rose with no issued access, required no request");
            cur.lat = 1; cur.rdata = '0;
          end else begin
            cur = rsp_q.pop_front();
          end
          active = 1'b1; cnt = 0;
        end
        cnt++;
        if (cnt >= cur.lat) begin
          dm_ack = 1'b1; dm_rdata = cur.rdata; active = 1'b0;
        end
      end else begin
        dm_ack = stray_all ? 1'b1 : 1'(($urandom & 3) == 0);
      end
    end
  end

  // Monitor: pops expectations when the DUT raises a request, an exception or reaches DONE.
  initial begin : monitor
    exp_t        cur, e;
    bit          in_req, done_next, done_now;
    int          stall_cnt;
    logic [63:0] shadow, s_wdata;
    logic [31:0] s_addr;
    logic [7:0]  s_strb;
    in_req = 0; done_next = 0; stall_cnt = 0; shadow = '0;
    s_wdata = '0; s_addr = '0; s_strb = '0;
    cur.exc = 0; cur.ld = 0; cur.lat = 0; cur.ldval = '0; cur.addr = '0; cur.wdata = '0; cur.strb = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        in_req = 0; done_next = 0; stall_cnt = 0; shadow = '0;
        continue;
      end
      done_now = done_next;
      if (done_now) begin
        chk("done_stall", 64'(stall_M), 64'd0);
        shadow = cur.ld ? cur.ldval : shadow;
        chk(cur.ld ? "load_data" : "store_keeps_load", load_data_M, shadow);
        chk("stall_cycles", 64'(stall_cnt), 64'(1 + cur.lat));
        stall_cnt = 0;
      end else begin
        chk("load_hold", load_data_M, shadow);
      end
      if (stall_M) stall_cnt++;
      if (exc_M) begin
        chk("exc_stall", 64'(stall_M), 64'd0);
        if (exp_q.size() == 0) fail("exc_unexpected", "exc_M=1 with no access issued, required 0");
        else begin
          e = exp_q.pop_front();
          chk("exc_expected", 64'(exc_M), 64'(e.exc));
        end
      end
      if (dm_req && !in_req) begin
        if (exp_q.size() == 0) fail("spurious_req", "dm_req=1 with no access pending, required 0");
        else begin
          cur = exp_q.pop_front();
          if (cur.exc) fail("req_on_exc", "dm_req=1 for an excepting access, required 0");
          chk("dm_addr", 64'(dm_addr), 64'(cur.addr));
          chk("dm_we", 64'(dm_we), 64'(!cur.ld));
          if (!cur.ld) begin
            chk("dm_wdata", dm_wdata, cur.wdata);
            chk("dm_strb", 64'(dm_strb), 64'(cur.strb));
          end
        end
        s_addr = dm_addr; s_wdata = dm_wdata; s_strb = dm_strb;
        in_req = 1;
      end else if (dm_req) begin
        chk("req_stable_addr", 64'(dm_addr), 64'(s_addr));
        chk("req_stable_wdata", dm_wdata, s_wdata);
        chk("req_stable_strb", 64'(dm_strb), 64'(s_strb));
      end else if (in_req) begin
        fail("req_dropped", "dm_req fell without dm_ack, required held high");
        in_req = 0;
      end
      done_next = in_req && dm_req && dm_ack;
      if (done_next) in_req = 0;
    end
  end

  initial begin : watchdog
    #2000000;
    fail("watchdog", "simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : stim
    rsp_t r;
    logic [2:0]  f3;
    logic [63:0] addr;
    int          sel, sz;

    // Reset held with an inputs pattern that would otherwise raise exc_M.
    valid_M = 1'b1; mem_read_M = 1'b1; funct3_M = 3'b010; alu_out_M = 64'h3002;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dm_req", 64'(dm_req), 64'd0);
    chk("rst_dm_we", 64'(dm_we), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr), 64'd0);
    chk("rst_dm_wdata", dm_wdata, 64'd0);
    chk("rst_dm_strb", 64'(dm_strb), 64'd0);
    chk("rst_load_data", load_data_M, 64'd0);
    chk("rst_stall", 64'(stall_M), 64'd0);
    chk("rst_exc", 64'(exc_M), 64'd0);
    rst = 1'b1;

    issue(1'b0, 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, {$urandom, $urandom}, 1);
    issue(1'b1, 1'b0, 3'b000, 64'h2003, {$urandom, $urandom}, 64'h0000000080000000, 3);
    issue(1'b1, 1'b0, 3'b101, 64'h2006, {$urandom, $urandom}, {16'hBEEF, 48'h123456789ABC}, 2);
    issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'h000000000000ABCD, {$urandom, $urandom}, 1);
    issue(1'b1, 1'b0, 3'b010, 64'h3002, {$urandom, $urandom}, {$urandom, $urandom}, 1);
    issue(1'b1, 1'b0, 3'b011, 64'h4008, {$urandom, $urandom}, 64'h8877665544332211, 2);
    issue(1'b1, 1'b0, 3'b110, 64'h400C, {$urandom, $urandom}, 64'hF00DCAFE_DEADBEEF, 1);
    issue(1'b1, 1'b1, 3'b100, 64'h4001, {$urandom, $urandom}, 64'h0000_0000_0000_FF00, 1);

    for (int t = 0; t < 300; t++) begin
      sel  = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      sz   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) addr[2:0] = 3'((int'(addr[2:0]) / sz) * sz);
      issue(sel != 1, sel != 0, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(1, 5));
      idle($urandom_range(0, 2));
    end

    // Reset during an outstanding load; the abandoned access must not complete later.
    valid_M = 1'b1; mem_read_M = 1'b1; mem_write_M = 1'b0; funct3_M = 3'b011; alu_out_M = 64'h5000;
    exp_q.push_back(model(1'b1, 3'b011, 64'h5000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1000));
    r.lat = 1000; r.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    rsp_q.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(dm_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 64'(dm_req), 64'd0);
    chk("mid_rst_stall", 64'(stall_M), 64'd0);
    chk("mid_rst_load", load_data_M, 64'd0);
    valid_M = 1'b0;
    stray_all = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_req", 64'(dm_req), 64'd0);
      chk("post_rst_load", load_data_M, 64'd0);
    end
    stray_all = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      sel  = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      sz   = 1 << f3[1:0];
      addr[2:0] = 3'((int'(addr[2:0]) / sz) * sz);
      issue(sel != 1, sel != 0, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(1, 4));
    end

    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("responder_drained", 64'(rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the RV64I pipeline, directly downstream of the E->M pipeline register.
- Consumes the registered ALU result (effective address) and rs2 data, and runs loads/stores against a variable-latency data memory over a req/ack handshake.
- Freezes the E->M register and all upstream stages with stall_M while an access is outstanding.
- Presents aligned, extended load data to the M->W register.

Parameters:
- XLEN, 64, datapath width (the dw type from DEF).
- DM_ADDR_W, 32, data-memory address width (low bits of alu_out_M).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (rst==0 resets)
- valid_M  in  1  M-stage holds a real instruction
- mem_read_M  in  1  instruction is a load
- mem_write_M  in  1  instruction is a store
- funct3_M  in  3  RV64I size/sign field
- alu_out_M  in  XLEN  effective byte address
- rs2_data_M  in  XLEN  store source data
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write
- dm_addr  out  DM_ADDR_W  doubleword-aligned address (bits[2:0] = 0)
- dm_wdata  out  64  lane-shifted store data
- dm_strb  out  8  byte write enables
- dm_ack  in  1  memory completes the access this cycle
- dm_rdata  in  64  read doubleword, valid with dm_ack
- stall_M  out  1  hold the E->M register and all upstream stages
- load_data_M  out  XLEN  extended load result for the M->W register
- exc_M  out  1  misaligned address or illegal funct3; access suppressed

Behaviour:
- FSM states IDLE, REQ, DONE. Reset state IDLE.
- Reset values: dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_strb=0, load_data_M=0. stall_M and exc_M are 0 under reset.
- Reset asserted mid-access forces IDLE and drops dm_req immediately. The abandoned access is not retried.
- acc = valid_M & (mem_read_M | mem_write_M). If both read and write are set, treat the access as a load.
- Alignment: off = alu_out_M[2:0]. Misaligned when:
  - halfword and off[0] != 0
  - word and off[1:0] != 0
  - doubleword and off != 0
- exc_M is combinational: acc & (misaligned | (load with funct3 = 111) | (store with funct3[2] = 1)). It is only asserted in IDLE.
- IDLE:
  - If acc & !exc_M: register dm_addr, dm_we, dm_wdata, dm_strb; set dm_req=1; go to REQ. stall_M = 1 this cycle.
  - Otherwise stay in IDLE, stall_M = 0 (pass-through, including the exception case).
- REQ:
  - dm_req is held at 1 with stable address/data/strb until dm_ack. stall_M = 1.
  - On dm_ack: drop dm_req, capture load_data_M (loads only; stores leave it unchanged), go to DONE.
- DONE: stall_M = 0 and load_data_M is valid, so the M->W register samples it at this edge. Unconditionally return to IDLE.
- DONE never accepts a new access, because its inputs still belong to the completed instruction.
- dm_ack seen in IDLE or DONE is ignored.
- Latency: minimum 3 cycles per memory op (accept, REQ+ack, DONE); stall_M is high for 1 + N cycles when the ack arrives in the Nth REQ cycle.
- Store lane: dm_wdata = rs2 data replicated per size and shifted left by off*8. dm_strb by size:
  - SB: 8'h01 << off
  - SH: 8'h03 << off
  - SW: 8'h0F << off
  - SD: 8'hFF
- Load extract: byte lane = dm_rdata >> (off*8), truncated to size, then extended:
  - sign-extended for LB, LH, LW, LD (000–011)
  - zero-extended for LBU, LHU, LWU (100–110)

Decomposition:
- DEF package gains:
  - enum lsu_state_t {IDLE, REQ, DONE}
  - funct3 constants F3_B/H/W/D/BU/HU/WU
  - byte-strobe type strb_t (logic[7:0])
- Sub-module mem_align (purely combinational): store lane shift + strobe generation, load extract + extension, misalignment check. Separately unit-testable.

Test Plan:
- Reset released, store SD addr 0x1000 data 0x1122334455667788, ack on 1st REQ cycle -> dm_strb=FF, dm_addr=0x1000, stall_M high exactly 2 cycles, DONE 1 cycle.
- LB addr 0x2003, dm_rdata=0x00000000_80000000 (byte3=0x80), ack after 3 REQ cycles -> load_data_M=0xFFFFFFFFFFFFFF80, stall_M high 4 cycles, dm_req stable throughout.
- LHU addr 0x2006, dm_rdata upper half 0xBEEF -> load_data_M=0x000000000000BEEF; SH addr 0x2006 data 0xABCD -> dm_strb=C0, dm_wdata[63:48]=0xABCD.
- LW addr 0x3002 (misaligned) -> exc_M=1 for one cycle, dm_req never asserted, stall_M=0.
- rst driven low while in REQ -> dm_req=0 immediately, state IDLE; a late dm_ack after rst releases is ignored and load_data_M stays 0.
- Back-to-back loads with no gap -> second access accepted only in the IDLE cycle after DONE, never in DONE.
